// File: rtl/multiword_add_pkg.sv
// Shared types and helpers for the multi-word add/subtract controller.
package multiword_add_pkg;

  localparam int LIMB_W    = 16;
  localparam int MAX_WORDS = 8;
  localparam int MAX_W     = LIMB_W * MAX_WORDS;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Extract limb 'idx' from a vector zero-extended to the widest legal operand.
  function automatic logic [LIMB_W-1:0] limb_of(input logic [MAX_W-1:0] vec,
                                                input logic [2:0]       idx);
    return vec[idx*LIMB_W +: LIMB_W];
  endfunction

endpackage

// File: rtl/carry_select_adder16_ci.sv
// 16-bit carry-select adder slice. The low byte ripples; the high byte is
// precomputed for both incoming carries and selected by the low-byte carry.
// The carry into bit 15 is exported so the caller can form signed overflow.
module carry_select_adder16_ci
  import multiword_add_pkg::*;
(
  input  logic [LIMB_W-1:0] a_i,
  input  logic [LIMB_W-1:0] b_i,
  input  logic              c_in_i,
  output logic [LIMB_W-1:0] sum_o,
  output logic              c_out_o,
  output logic              c15_o
);

  logic [8:0] lo_sum;
  logic [7:0] hi7_c0;
  logic [7:0] hi7_c1;
  logic       c15_c0, c15_c1;
  logic       s15_c0, s15_c1;
  logic       co_c0, co_c1;

  // Low byte ripple plus both speculative versions of the high byte.
  always_comb begin
    lo_sum = {1'b0, a_i[7:0]} + {1'b0, b_i[7:0]} + {8'd0, c_in_i};
    // bits 14:8 with a spare top bit that becomes the carry into bit 15
    hi7_c0 = {1'b0, a_i[14:8]} + {1'b0, b_i[14:8]};
    hi7_c1 = {1'b0, a_i[14:8]} + {1'b0, b_i[14:8]} + 8'd1;
    c15_c0 = hi7_c0[7];
    c15_c1 = hi7_c1[7];
    s15_c0 = a_i[15] ^ b_i[15] ^ c15_c0;
    s15_c1 = a_i[15] ^ b_i[15] ^ c15_c1;
    co_c0  = (a_i[15] & b_i[15]) | (c15_c0 & (a_i[15] ^ b_i[15]));
    co_c1  = (a_i[15] & b_i[15]) | (c15_c1 & (a_i[15] ^ b_i[15]));
  end

  // Select the high byte result using the real carry out of the low byte.
  always_comb begin
    sum_o[7:0] = lo_sum[7:0];
    if (lo_sum[8]) begin
      sum_o[15:8] = {s15_c1, hi7_c1[6:0]};
      c_out_o     = co_c1;
      c15_o       = c15_c1;
    end else begin
      sum_o[15:8] = {s15_c0, hi7_c0[6:0]};
      c_out_o     = co_c0;
      c15_o       = c15_c0;
    end
  end

endmodule

// File: rtl/multiword_add_controller.sv
// Wide add/subtract built from one shared 16-bit slice, one limb per clock,
// least significant limb first. WORDS must be in 2..8.
//
// state | meaning
// IDLE  | waiting for Run; operands latched when Run is seen
// ADD   | one limb per edge through the shared slice, idx selects the limb
// DONE  | result complete, Done pulses for this one cycle
module multiword_add_controller
  import multiword_add_pkg::*;
#(
  parameter int WORDS = 4
) (
  input  logic                    Clk,
  input  logic                    Reset,
  input  logic                    Run,
  input  logic                    Sub,
  input  logic [LIMB_W*WORDS-1:0] A,
  input  logic [LIMB_W*WORDS-1:0] B,
  output logic [LIMB_W*WORDS-1:0] Sum,
  output logic                    CO,
  output logic                    V,
  output logic                    Busy,
  output logic                    Done
);

  localparam int W     = LIMB_W * WORDS;
  localparam int IDX_W = $clog2(WORDS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             carry_q, carry_d;
  logic [W-1:0]     a_q, a_d;
  logic [W-1:0]     b_q, b_d;
  logic [W-1:0]     sum_q;
  logic             co_q, co_d;
  logic             v_q, v_d;
  logic [WORDS-1:0] limb_we;

  logic [MAX_W-1:0]  a_ext, b_ext;
  logic [LIMB_W-1:0] slice_a, slice_b, slice_sum;
  logic              slice_co, slice_c15;

  // Zero-extend operands so the shared limb helper works for any WORDS.
  always_comb begin
    a_ext          = '0;
    b_ext          = '0;
    a_ext[W-1:0]   = a_q;
    b_ext[W-1:0]   = b_q;
    slice_a        = limb_of(a_ext, 3'(idx_q));
    slice_b        = limb_of(b_ext, 3'(idx_q));
  end

  carry_select_adder16_ci u_slice (
    .a_i     (slice_a),
    .b_i     (slice_b),
    .c_in_i  (carry_q),
    .sum_o   (slice_sum),
    .c_out_o (slice_co),
    .c15_o   (slice_c15)
  );

  // Next-state, datapath register updates and limb write-enable decode.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    co_d    = co_q;
    v_d     = v_q;
    limb_we = '0;
    case (state_q)
      IDLE: begin
        if (Run) begin
          a_d     = A;
          // subtraction as A + ~B + 1: invert now, carry-in of 1 below
          b_d     = Sub ? ~B : B;
          carry_d = Sub;
          idx_d   = '0;
          state_d = ADD;
        end
      end
      ADD: begin
        limb_we[idx_q] = 1'b1;
        carry_d        = slice_co;
        if (idx_q == LAST_IDX) begin
          co_d    = slice_co;
          v_d     = slice_c15 ^ slice_co;
          state_d = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Control and operand registers.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      co_q    <= 1'b0;
      v_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      co_q    <= co_d;
      v_q     <= v_d;
    end
  end

  // Result register; only the limb selected by idx is written each ADD edge.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      sum_q <= '0;
    end else begin
      for (int i = 0; i < WORDS; i++) begin
        if (limb_we[i]) begin
          sum_q[i*LIMB_W +: LIMB_W] <= slice_sum;
        end
      end
    end
  end

  assign Sum  = sum_q;
  assign CO   = co_q;
  assign V    = v_q;
  assign Busy = (state_q != IDLE);
  assign Done = (state_q == DONE);

endmodule
